mul_div_unit: RTL and testbench

Iterative RV64M multiply/divide unit serving the execute stage. It accepts one operation at a time: operands, per-operand signedness, a mul/div select and a word-mode flag. It runs a radix-2 shift-add multiply or a restoring divide over 64 cycles and returns two 64-bit results. Results go back to the execute stage for writeback muxing:
- `result_1_o`: mul low / quotient.
- `result_2_o`: mul high / remainder.

---
 rtl/mul_div_unit_pkg.sv | 23 ++
 rtl/mul_div_unit.sv | 169 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared sign encodings, state encoding and small helpers for the iterative
// RV64M multiply/divide unit.
package mul_div_unit_pkg;

    localparam logic       MULDIV_SIGN    = 1'b1;
    localparam logic       MULDIV_UNSIGN  = 1'b0;
    localparam logic [5:0] MULDIV_CNT_MAX = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] word_ext(input logic [31:0] v, input logic is_signed);
        return is_signed ? sext32(v) : {32'd0, v};
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply and restoring
// divide over 64 cycles, with magnitude arithmetic and a final sign fix.
module mul_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic            mul_en_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            rs1_sign_i,
    input  logic            rs2_sign_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] result_1_o,
    output logic [XLEN-1:0] result_2_o
);
    import mul_div_unit_pkg::*;

    localparam int              ACCW      = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_NEG_W = {{(XLEN-31){1'b1}}, 31'd0};

    muldiv_state_e   state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            mul_q, mul_d, word_q, word_d;
    logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [XLEN-1:0] abs_a_q, abs_a_d, abs_b_q, abs_b_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [XLEN-1:0] res1_q, res1_d, res2_q, res2_d;

    logic            sign_a, sign_b, in_neg_a, in_neg_b, div_zero, div_ovf;
    logic [XLEN-1:0] op_a, op_b, in_abs_a, in_abs_b;

    always_comb begin
        sign_a   = (rs1_sign_i == MULDIV_SIGN);
        sign_b   = (rs2_sign_i != MULDIV_UNSIGN);
        op_a     = word_i ? word_ext(rs1_data_i[31:0], sign_a) : rs1_data_i;
        op_b     = word_i ? word_ext(rs2_data_i[31:0], sign_b) : rs2_data_i;
        in_neg_a = sign_a & op_a[XLEN-1];
        in_neg_b = sign_b & op_b[XLEN-1];
        in_abs_a = in_neg_a ? -op_a : op_a;
        in_abs_b = in_neg_b ? -op_b : op_b;
        div_zero = (op_b == '0);
        div_ovf  = sign_a & sign_b & (op_b == '1) & (op_a == (word_i ? MIN_NEG_W : MIN_NEG_D));
    end

    // Multiply keeps {hi, lo} with the multiplier draining out of lo; divide
    // keeps {rem, quo} with the dividend draining out of the top of quo.
    logic [XLEN:0]   mul_sum, rem_sh;
    logic [XLEN-1:0] rem_trial;
    logic            rem_ge;
    logic [ACCW-1:0] mul_next, div_next, step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[ACCW-1:XLEN]} + (acc_q[0] ? {1'b0, abs_a_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh    = acc_q[ACCW-1:XLEN-1];
        rem_ge    = (rem_sh >= {1'b0, abs_b_q});
        rem_trial = rem_sh[XLEN-1:0] - abs_b_q;
        div_next  = {(rem_ge ? rem_trial : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
        step      = mul_q ? mul_next : div_next;
    end

    logic [ACCW-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, raw1, raw2, fin1, fin2;

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -step : step;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem_fix  = neg_a_q ? -step[ACCW-1:XLEN] : step[ACCW-1:XLEN];
        raw1     = mul_q ? prod_fix[XLEN-1:0] : quo_fix;
        raw2     = mul_q ? prod_fix[ACCW-1:XLEN] : rem_fix;
        fin1     = word_q ? sext32(raw1[31:0]) : raw1;
        fin2     = word_q ? sext32(raw2[31:0]) : raw2;
    end

    // Results are registered on entry to DONE so they are valid during the pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        word_d  = word_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        abs_a_d = abs_a_q;
        abs_b_d = abs_b_q;
        acc_d   = acc_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    mul_d   = mul_en_i;
                    word_d  = word_i;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    abs_a_d = in_abs_a;
                    abs_b_d = in_abs_b;
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, (mul_en_i ? in_abs_b : in_abs_a)};
                    state_d = ST_CALC;
                    if (!mul_en_i && div_zero) begin
                        res1_d  = '1;
                        res2_d  = word_i ? sext32(op_a[31:0]) : op_a;
                        state_d = ST_DONE;
                    end else if (!mul_en_i && div_ovf) begin
                        res1_d  = op_a;
                        res2_d  = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                acc_d = step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == MULDIV_CNT_MAX) begin
                    res1_d  = fin1;
                    res2_d  = fin2;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
            res1_d  = res1_q;
            res2_d  = res2_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            word_q  <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            abs_a_q <= '0;
            abs_b_q <= '0;
            acc_q   <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            word_q  <= word_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            abs_a_q <= abs_a_d;
            abs_b_q <= abs_b_d;
            acc_q   <= acc_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
        end
    end

    assign ready_o      = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_DONE);
    assign result_1_o   = res1_q;
    assign result_2_o   = res2_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand-written
// flush/reset/busy sequences, and randomized ops against an arithmetic model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam logic S = MULDIV_SIGN;
    localparam logic U = MULDIV_UNSIGN;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0, mul_en_i = 1'b0, word_i = 1'b0;
    logic [63:0] rs1_data_i = '0, rs2_data_i = '0;
    logic        rs1_sign_i = 1'b0, rs2_sign_i = 1'b0, flush_i = 1'b0;
    logic        ready_o, resp_valid_o;
    logic [63:0] result_1_o, result_2_o;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .mul_en_i(mul_en_i),
        .word_i(word_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rs1_sign_i(rs1_sign_i), .rs2_sign_i(rs2_sign_i), .flush_i(flush_i),
        .ready_o(ready_o), .resp_valid_o(resp_valid_o),
        .result_1_o(result_1_o), .result_2_o(result_2_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mul, word, sa, sb;
        logic [63:0] a, b, e1, e2;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
        end
    endtask

    // Waits (bounded) for ready, presents one request, returns just after the accepting edge.
    task automatic startOp(input logic mul, input logic word, input logic sa, input logic sb,
                           input logic [63:0] a, input logic [63:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        mul_en_i = mul; word_i = word; rs1_sign_i = sa; rs2_sign_i = sb;
        rs1_data_i = a; rs2_data_i = b; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    // Counts falling edges from now; lat is the index of the one seeing resp_valid_o, or -1.
    task automatic waitResp(input int maxc, output int lat, output logic [63:0] r1, output logic [63:0] r2);
        lat = -1; r1 = '0; r2 = '0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (resp_valid_o) begin
                lat = c; r1 = result_1_o; r2 = result_2_o;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic mul, input logic word, input logic sa, input logic sb,
                                 input logic [63:0] a, input logic [63:0] b,
                                 output int lat, output logic [63:0] r1, output logic [63:0] r2,
                                 output logic rdy_after);
        startOp(mul, word, sa, sb, a, b);
        waitResp(100, lat, r1, r2);
        rdy_after = 1'b0;
        if (lat > 0) begin
            @(negedge clk);
            rdy_after = ready_o;
        end
    endtask

    // RISC-V M-extension semantics computed with plain wide arithmetic.
    function automatic void model(input logic mul, input logic word, input logic sa, input logic sb,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r1, output logic [63:0] r2, output int lat);
        logic [63:0]  ea, eb;
        logic [127:0] wa, wb, p;
        logic         sga, sgb;
        sga = (sa == MULDIV_SIGN);
        sgb = (sb == MULDIV_SIGN);
        ea  = word ? (sga ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
        eb  = word ? (sgb ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
        lat = 65;
        if (mul) begin
            wa = sga ? {{64{ea[63]}}, ea} : {64'd0, ea};
            wb = sgb ? {{64{eb[63]}}, eb} : {64'd0, eb};
            p  = wa * wb;
            r1 = p[63:0];
            r2 = p[127:64];
        end else if (eb == 64'd0) begin
            r1 = ONES; r2 = ea; lat = 1;
        end else if (sga && sgb && eb == ONES &&
                     ea == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
            r1 = ea; r2 = 64'd0; lat = 1;
        end else if (sga && sgb) begin
            r1 = 64'($signed(ea) / $signed(eb));
            r2 = 64'($signed(ea) % $signed(eb));
        end else begin
            r1 = ea / eb;
            r2 = ea % eb;
        end
        if (word) begin
            r1 = {{32{r1[31]}}, r1[31:0]};
            r2 = {{32{r2[31]}}, r2[31:0]};
        end
    endfunction

    initial begin
        int          lat;
        logic [63:0] r1, r2, e1, e2;
        logic        rdy;
        int          elat;

        vecs.push_back('{"mul_7_x_m3", 1'b1, 1'b0, S, S, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, ONES, 65});
        vecs.push_back('{"mulhu", 1'b1, 1'b0, U, U, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65});
        vecs.push_back('{"mulhsu", 1'b1, 1'b0, S, U, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, ONES, 65});
        vecs.push_back('{"div_m7_2", 1'b0, 1'b0, S, S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 65});
        vecs.push_back('{"divu_m7_2", 1'b0, 1'b0, U, U, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 65});
        vecs.push_back('{"div_5_by_0", 1'b0, 1'b0, S, S, 64'd5, 64'd0, ONES, 64'd5, 1});
        vecs.push_back('{"div_ovf", 1'b0, 1'b0, S, S, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 64'd0, 1});
        vecs.push_back('{"divw_ovf", 1'b0, 1'b1, S, S, 64'h0000_0001_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 64'd0, 1});
        vecs.push_back('{"mulw", 1'b1, 1'b1, S, S, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 65});
        vecs.push_back('{"divw_m7_2", 1'b0, 1'b1, S, S, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 65});
        vecs.push_back('{"divuw_by_0", 1'b0, 1'b1, U, U, 64'hDEAD_BEEF_8000_0005, 64'hFFFF_FFFF_0000_0000, ONES, 64'hFFFF_FFFF_8000_0005, 1});

        // Reset state
        @(negedge clk);
        checkOutput("reset_ready", 64'(ready_o), 64'd1);
        checkOutput("reset_resp", 64'(resp_valid_o), 64'd0);
        checkOutput("reset_r1", result_1_o, 64'd0);
        checkOutput("reset_r2", result_2_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].mul, vecs[i].word, vecs[i].sa, vecs[i].sb, vecs[i].a, vecs[i].b, lat, r1, r2, rdy);
            checkOutput({vecs[i].name, "_r1"}, r1, vecs[i].e1);
            checkOutput({vecs[i].name, "_r2"}, r2, vecs[i].e2);
            checkOutput({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            checkOutput({vecs[i].name, "_ready_after"}, 64'(rdy), 64'd1);
        end

        // A request while busy is ignored
        startOp(1'b1, 1'b0, S, S, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (10) @(negedge clk);
        mul_en_i = 1'b0; rs1_data_i = 64'd100; rs2_data_i = 64'd3; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        waitResp(100, lat, r1, r2);
        checkOutput("busy_lat", 64'(lat), 64'd55);
        checkOutput("busy_r1", r1, 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("busy_r2", r2, ONES);

        // Flush at cycle t+30 of a multiply
        startOp(1'b1, 1'b0, U, U, 64'h1234, 64'h10);
        repeat (30) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_ready", 64'(ready_o), 64'd1);
        checkOutput("flush_resp", 64'(resp_valid_o), 64'd0);
        waitResp(80, lat, r1, r2);
        checkOutput("flush_no_resp", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("flush_r1_kept", result_1_o, 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("flush_r2_kept", result_2_o, ONES);
        applyStimulus(1'b1, 1'b0, U, U, 64'h1234, 64'h10, lat, r1, r2, rdy);
        checkOutput("after_flush_r1", r1, 64'h12340);
        checkOutput("after_flush_r2", r2, 64'd0);
        checkOutput("after_flush_lat", 64'(lat), 64'd65);

        // Flush beats a simultaneous request in IDLE
        @(negedge clk);
        mul_en_i = 1'b1; rs1_data_i = 64'd3; rs2_data_i = 64'd3; req_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1 begin req_valid_i = 1'b0; flush_i = 1'b0; end
        @(negedge clk);
        checkOutput("flush_req_ready", 64'(ready_o), 64'd1);
        waitResp(70, lat, r1, r2);
        checkOutput("flush_req_dropped", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset pulse mid-divide
        startOp(1'b0, 1'b0, S, S, 64'd1000, 64'd7);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready", 64'(ready_o), 64'd1);
        checkOutput("midrst_resp", 64'(resp_valid_o), 64'd0);
        checkOutput("midrst_r1", result_1_o, 64'd0);
        checkOutput("midrst_r2", result_2_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        waitResp(80, lat, r1, r2);
        checkOutput("midrst_no_resp", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b0, 1'b0, U, U, 64'd1000, 64'd7, lat, r1, r2, rdy);
        checkOutput("after_rst_r1", r1, 64'd142);
        checkOutput("after_rst_r2", r2, 64'd6);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        m, w, sa, sb;
            logic [63:0] a, b;
            int          sel;
            m   = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            sa  = 1'($urandom_range(0, 1));
            sb  = m ? 1'($urandom_range(0, 1)) : sa;
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            sel = int'($urandom_range(0, 9));
            if (sel == 0) b = 64'd0;
            else if (sel == 1) b = 64'($urandom_range(1, 15));
            else if (sel == 2) begin
                a = w ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
                b = ONES;
            end
            model(m, w, sa, sb, a, b, e1, e2, elat);
            applyStimulus(m, w, sa, sb, a, b, lat, r1, r2, rdy);
            checkOutput($sformatf("rand%0d_r1", i), r1, e1);
            checkOutput($sformatf("rand%0d_r2", i), r2, e2);
            checkOutput($sformatf("rand%0d_lat", i), 64'(lat), 64'(elat));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
